// File: rtl/inv_key_schedule.sv
// AES-128 inverse key scheduler: loaded with the round-10 key, streams round keys 10..0.
// Define INV_KS_EQINV_EN to emit InvMixColumns'd keys for rounds 1..9 (equivalent inverse cipher).
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Forward expansion's g(): RotWord, SubWord, then Rcon into the top byte.
    function automatic logic [31:0] function_g(input logic [31:0] w, input logic [3:0] i);
        return sub_word({w[23:0], w[31:24]}) ^ {rcon(i), 24'h0};
    endfunction

`ifdef INV_KS_EQINV_EN
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int k = 0; k < 4; k++) begin
            a[k]  = c[31-8*k -: 8];
            x2    = xtime(a[k]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[k] = x8 ^ a[k];
            mb[k] = x8 ^ x2 ^ a[k];
            md[k] = x8 ^ x4 ^ a[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
    logic [127:0] prev_key;
    logic [127:0] out_key;
    logic [31:0]  w0, w1, w2, w3, n0, n1, n2, n3;

    // Undo one expansion step; the Rcon index is the round of the key being undone.
    always_comb begin
        w0 = key_q[127:96];
        w1 = key_q[95:64];
        w2 = key_q[63:32];
        w3 = key_q[31:0];
        n3 = w3 ^ w2;
        n2 = w2 ^ w1;
        n1 = w1 ^ w0;
        n0 = w0 ^ function_g(n3, round_q);
        prev_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd10;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

`ifdef INV_KS_EQINV_EN
    always_comb begin
        out_key = key_q;
        if (round_q != 4'd0 && round_q != 4'd10)
            out_key = {inv_mix_col(key_q[127:96]), inv_mix_col(key_q[95:64]),
                       inv_mix_col(key_q[63:32]),  inv_mix_col(key_q[31:0])};
    end
`else
    assign out_key = key_q;
`endif

    // Outputs read as zero whenever no key is being offered.
    assign busy     = (state_q == EMIT);
    assign rk_valid = (state_q == EMIT);
    assign rk_out   = rk_valid ? out_key : '0;
    assign rk_round = rk_valid ? round_q : '0;
    assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: forward-expands a round-0 key with an algorithmic AES model,
// feeds round key 10 to the DUT and checks the streamed keys in reverse order.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_rk [0:10];
    logic [127:0] cap    [0:10];

    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    inv_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_round(rk_round),
        .done(done)
    );

    always #5 clk = ~clk;

    // ---- reference model: GF(2^8) arithmetic from first principles ----
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_m(input int i);
        logic [7:0] r = 8'h01;
        for (int k = 1; k < i; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [31:0] imc_word(input logic [31:0] c);
        logic [7:0] m [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                 '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        logic [31:0] r = '0;
        for (int row = 0; row < 4; row++) begin
            logic [7:0] acc = 8'h00;
            for (int col = 0; col < 4; col++) acc = acc ^ gmul(m[row][col], c[31-8*col -: 8]);
            r[31-8*row -: 8] = acc;
        end
        return r;
    endfunction

    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_m(i/4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] expv(input int r);
`ifdef INV_KS_EQINV_EN
        if (r >= 1 && r <= 9)
            return {imc_word(exp_rk[r][127:96]), imc_word(exp_rk[r][95:64]),
                    imc_word(exp_rk[r][63:32]),  imc_word(exp_rk[r][31:0])};
`endif
        return exp_rk[r];
    endfunction

    // ---- scenarios ----
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        #3;
        tests++; if ({busy, rk_valid, done} !== 3'b000) begin fails++;
            $display("FAIL reset_flags busy/valid/done=%b want 000", {busy, rk_valid, done}); end
        tests++; if (rk_out !== '0 || rk_round !== 4'd0) begin fails++;
            $display("FAIL reset_data rk_out=%h rk_round=%0d want 0", rk_out, rk_round); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Loads key 10 of k0's schedule and streams it; optional backpressure, ignored start
    // pokes, mid-run reset after abort_after transfers, or a restart in the done cycle.
    task automatic test_stream(input string nm, input logic [127:0] k0, input bit rand_rdy,
                               input bit poke, input int abort_after, input bit restart);
        int mround = 10;
        int ntx = 0;
        int cyc = 0;
        bit rdy;
        expand(k0);
        @(negedge clk); start = 1'b1; key_in = exp_rk[10];
        @(posedge clk); @(negedge clk); start = 1'b0;
        while (ntx < 11 && cyc < 300) begin
            tests++; if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin fails++;
                $display("FAIL %s_flags cyc%0d valid/busy/done=%b%b%b want 110", nm, cyc, rk_valid, busy, done); end
            tests++; if (rk_round !== 4'(mround) || rk_out !== expv(mround)) begin fails++;
                $display("FAIL %s_key cyc%0d round=%0d key=%h want round=%0d key=%h",
                         nm, cyc, rk_round, rk_out, mround, expv(mround)); end
            if (ntx == abort_after) begin
                rst_n = 1'b0; #2;
                tests++; if ({busy, rk_valid, done} !== 3'b000 || rk_out !== '0 || rk_round !== 4'd0) begin
                    fails++; $display("FAIL %s_abort flags=%b key=%h round=%0d want zeros", nm,
                                      {busy, rk_valid, done}, rk_out, rk_round); end
                @(negedge clk); rst_n = 1'b1; @(negedge clk);
                tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++;
                    $display("FAIL %s_abort_idle done=%b busy=%b want 0 0", nm, done, busy); end
                return;
            end
            cap[mround] = rk_out;
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = rdy;
            if (poke) begin start = 1'($urandom_range(0, 1)); key_in = {$urandom, $urandom, $urandom, $urandom}; end
            @(posedge clk);
            if (rdy) begin ntx++; mround--; end
            @(negedge clk); cyc++;
        end
        start = 1'b0; rk_ready = 1'b0;
        tests++; if (ntx != 11) begin fails++;
            $display("FAIL %s_timeout transfers=%0d want 11", nm, ntx); end
        tests++; if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin fails++;
            $display("FAIL %s_done done/busy/valid=%b%b%b want 100", nm, done, busy, rk_valid); end
        if (restart) begin
            start = 1'b1; key_in = exp_rk[10];
            @(posedge clk); @(negedge clk); start = 1'b0;
            tests++; if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk_out !== exp_rk[10]) begin fails++;
                $display("FAIL %s_restart valid=%b round=%0d key=%h want 1 10 %h", nm, rk_valid, rk_round, rk_out, exp_rk[10]); end
            rk_ready = 1'b1;
            repeat (11) @(posedge clk);
            @(negedge clk); rk_ready = 1'b0;
            tests++; if (done !== 1'b1) begin fails++;
                $display("FAIL %s_restart_done done=%b want 1", nm, done); end
        end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++;
            $display("FAIL %s_done_pulse done=%b want 0", nm, done); end
    endtask

    task automatic test_fips_consts();
        tests++; if (cap[10] !== FIPS_K10) begin fails++;
            $display("FAIL fips_r10 got=%h want=%h", cap[10], FIPS_K10); end
        tests++; if (cap[0] !== FIPS_K0) begin fails++;
            $display("FAIL fips_r0 got=%h want=%h", cap[0], FIPS_K0); end
`ifndef INV_KS_EQINV_EN
        tests++; if (cap[9] !== FIPS_K9) begin fails++;
            $display("FAIL fips_r9 got=%h want=%h", cap[9], FIPS_K9); end
`else
        tests++; if (cap[9] !== {imc_word(FIPS_K9[127:96]), imc_word(FIPS_K9[95:64]),
                                 imc_word(FIPS_K9[63:32]), imc_word(FIPS_K9[31:0])}) begin fails++;
            $display("FAIL fips_r9_eqinv got=%h", cap[9]); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream("fips", FIPS_K0, 1'b0, 1'b0, -1, 1'b0);
        test_fips_consts();
        test_stream("backpressure", FIPS_K0, 1'b1, 1'b0, -1, 1'b0);
        test_fips_consts();
        test_stream("start_ignored", FIPS_K0, 1'b1, 1'b1, -1, 1'b0);
        test_stream("abort", FIPS_K0, 1'b0, 1'b0, 4, 1'b0);
        test_stream("after_abort", FIPS_K0, 1'b0, 1'b0, -1, 1'b0);
        test_stream("start_in_done", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, -1, 1'b1);
        for (int n = 0; n < 3; n++)
            test_stream("random", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
